timed_priority_arbiter: RTL and testbench
=========================================

TIMED_PRIORITY_ARBITER -- requirements
Module: timed_priority_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: channel count, legal range 2..8; channel 0 is the urgent channel.
REQ-002 SHALL have parameter MAX_HOLD, default 2: maximum cycles a non-urgent grant is held before cut-off, legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: width of the event counters.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, N bits: per-channel access request pulse or level.
REQ-007 SHALL have port done, input, N bits: per-channel release of a held grant.
REQ-008 SHALL have port grant, output, N bits: one-hot or zero registered grant.
REQ-009 SHALL have port accmodule, output, $clog2(N+1) bits: 0 = idle, k+1 = channel k granted.
REQ-010 SHALL have port pending, output, N bits: latched outstanding requests.
REQ-011 SHALL have port nb_interrupts, output, CNT_W bits: count of urgent preemptions.
REQ-012 SHALL have port nb_timeouts, output, CNT_W bits: count of MAX_HOLD cut-offs.

Function
REQ-013 SHALL set pending[k] on any edge where req[k]=1 and channel k is not currently granted, and SHALL clear it on the edge that grants k.
REQ-014 SHALL ignore req[k] while channel k is granted.
REQ-015 SHALL ignore done[k] unless channel k is granted.
REQ-016 SHALL implement states IDLE, GRANT_N (a non-urgent channel is held) and GRANT_U (channel 0 is held).
REQ-017 SHALL arbitrate on pending|req, so a grant appears one cycle after req is sampled, with no extra latency.
REQ-018 SHALL give channel 0 absolute priority: from IDLE or on any release edge, channel 0 wins if requesting.
REQ-019 SHALL let a channel-0 request in GRANT_N preempt the held channel on the next edge: state becomes GRANT_U, the preempted channel's pending bit is set, and nb_interrupts increments.
REQ-020 SHALL hold GRANT_U until done[0]; it has no timeout, and a new req[0] during GRANT_U is ignored.
REQ-021 SHALL arbitrate non-urgent channels 1..N-1 round-robin, searching upward from the last granted non-urgent channel plus one and wrapping past N-1 to channel 1; after reset the pointer gives channel 1 first.
REQ-022 SHALL run a hold counter that loads 1 on each grant and increments each cycle in GRANT_N.
REQ-023 SHALL release the grant on the edge where the counter equals MAX_HOLD and done is not asserted, incrementing nb_timeouts; this is a cut-off, and the cut-off channel is not re-pended.
REQ-024 SHALL perform the release and the next arbitration on the same edge: on done or cut-off with other requests present, the grant moves directly to the winner with no idle cycle.
REQ-025 SHALL return to IDLE with grant=0 and accmodule=0 on release when no requests are present.
REQ-026 SHALL treat simultaneous done[k] and req[0] on a non-urgent grant as a done followed by an urgent grant, with no interrupt counted.
REQ-027 SHALL keep grant and accmodule consistent at all times, with grant one-hot or zero.
REQ-028 SHALL make both counters saturate at 2^CNT_W-1, with no wrap.

Reset
REQ-029 SHALL, while reset=0 (asynchronous, any cycle including mid-grant), force state=IDLE, grant=0, accmodule=0, pending=0, the round-robin pointer to channel 1, the hold counter to 0, and both counters to 0.
REQ-030 SHALL resume normal arbitration on the first rising edge after reset deasserts.

Verification (N=4, MAX_HOLD=2, CNT_W=8)
REQ-031 Bench SHALL cover: reset low mid-GRANT_N -> grant=0000, accmodule=0 immediately, before any clock edge, and counters=0.
REQ-032 Bench SHALL cover: req=0110 for one cycle, no done -> ch1 is granted for 2 cycles (accmodule=2), then ch2 for 2 cycles (accmodule=3), then IDLE; nb_timeouts=2.
REQ-033 Bench SHALL cover: ch2 granted, req=0001 in its first cycle -> next edge grant=0001, accmodule=1, nb_interrupts=1, pending[2]=1; done=0001 -> ch2 is re-granted on the same edge.
REQ-034 Bench SHALL cover: ch0 granted, no done for 10 cycles -> grant stays at 0001 and nb_timeouts is unchanged.
REQ-035 Bench SHALL cover: ch1 granted, done=0010 with req=1000 on the same cycle -> grant=1000 on the next edge, with no idle cycle and no timeout counted.
REQ-036 Bench SHALL cover: 300 forced preemptions -> nb_interrupts=255, saturated.

Source files
------------

// File: rtl/timed_priority_arbiter.sv
// -----------------------------------------------------------------------------
// timed_priority_arbiter
//
// Grants one of N channels at a time. Channel 0 is urgent: it wins every
// arbitration it takes part in and preempts a held non-urgent grant. Channels
// 1..N-1 share round-robin and are cut off after MAX_HOLD cycles.
//
// Handshake: req[k] is sampled on every rising edge while channel k is not
// granted and is remembered in pending[k] until k is granted. done[k] is
// sampled only while grant[k]=1 and releases the grant on that same edge.
// The next owner, if any, is granted on the releasing edge.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   req[N]        per-channel request (pulse or level)
//   done[N]       per-channel release of a held grant
//   grant[N]      one-hot or zero grant, decoded from registered state
//   accmodule     0 = idle, k+1 = channel k granted
//   pending[N]    latched outstanding requests
//   nb_interrupts saturating count of urgent preemptions
//   nb_timeouts   saturating count of MAX_HOLD cut-offs
//   dbg_state     FSM state (0 IDLE, 1 GRANT_N, 2 GRANT_U)
// -----------------------------------------------------------------------------
module timed_priority_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 2,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           done,
    output logic [N-1:0]           grant,
    output logic [$clog2(N+1)-1:0] accmodule,
    output logic [N-1:0]           pending,
    output logic [CNT_W-1:0]       nb_interrupts,
    output logic [CNT_W-1:0]       nb_timeouts,
    output logic [1:0]             dbg_state
);

    localparam int IW = $clog2(N);
    localparam int AW = $clog2(N+1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_N = 2'd1,
        GRANT_U = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   cur, cur_n;     // currently granted channel
    logic [IW-1:0]   last, last_n;   // last granted non-urgent channel
    logic [7:0]      hold, hold_n;
    logic [N-1:0]    pend_n;
    logic [N-1:0]    eff;            // requests taking part in arbitration
    logic            inc_int, inc_to;
    logic            do_arb;
    logic            rr_found;
    logic [IW-1:0]   rr_idx;

    // A granted channel's own req is ignored, so mask it out with grant.
    assign eff = pending | (req & ~grant);

    // Round-robin search over 1..N-1 starting at last+1. The loop runs in
    // reverse so the first candidate in search order is the final winner.
    always_comb begin
        int j;
        logic [IW-1:0] cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = N - 1; i >= 1; i--) begin
            j    = ((int'(last) - 1 + i) % (N - 1)) + 1;
            cand = IW'(j);
            if (eff[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cur           <= '0;
            last          <= IW'(N - 1);
            hold          <= '0;
            pending       <= '0;
            nb_interrupts <= '0;
            nb_timeouts   <= '0;
        end else begin
            state   <= state_n;
            cur     <= cur_n;
            last    <= last_n;
            hold    <= hold_n;
            pending <= pend_n;
            if (inc_int && nb_interrupts != '1)
                nb_interrupts <= nb_interrupts + 1'b1;
            if (inc_to && nb_timeouts != '1)
                nb_timeouts <= nb_timeouts + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        cur_n   = cur;
        last_n  = last;
        hold_n  = hold;
        pend_n  = eff;
        inc_int = 1'b0;
        inc_to  = 1'b0;
        do_arb  = 1'b0;
        case (state)
            IDLE: do_arb = 1'b1;
            GRANT_U: begin
                if (done[0])
                    do_arb = 1'b1;
            end
            GRANT_N: begin
                if (done[cur]) begin
                    // Done wins over a simultaneous urgent request: plain
                    // release, then channel 0 wins the arbitration below.
                    do_arb = 1'b1;
                end else if (eff[0]) begin
                    state_n     = GRANT_U;
                    pend_n[cur] = 1'b1;
                    pend_n[0]   = 1'b0;
                    cur_n       = '0;
                    hold_n      = 8'd1;
                    inc_int     = 1'b1;
                end else if (hold == 8'(MAX_HOLD)) begin
                    inc_to = 1'b1;
                    do_arb = 1'b1;
                end else begin
                    hold_n = hold + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_arb) begin
            if (eff[0]) begin
                state_n   = GRANT_U;
                cur_n     = '0;
                hold_n    = 8'd1;
                pend_n[0] = 1'b0;
            end else if (rr_found) begin
                state_n        = GRANT_N;
                cur_n          = rr_idx;
                last_n         = rr_idx;
                hold_n         = 8'd1;
                pend_n[rr_idx] = 1'b0;
            end else begin
                state_n = IDLE;
                hold_n  = '0;
            end
        end
    end

    // Output decode
    always_comb begin
        grant     = '0;
        accmodule = '0;
        if (state != IDLE) begin
            grant[cur] = 1'b1;
            accmodule  = AW'(cur) + AW'(1);
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_timed_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timed_priority_arbiter
//
// Inputs change on the falling edge; the reference model computes what the
// outputs must be after the next rising edge and queues it. A monitor samples
// 1 time unit after each rising edge and compares against the queue head.
// Directed scenarios add explicit checks against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_timed_priority_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 2;
    localparam int CNT_W    = 8;
    localparam int AW       = $clog2(N+1);
    localparam int EW       = N + AW + N + CNT_W + CNT_W;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req;
    logic [N-1:0]     done;
    logic [N-1:0]     grant;
    logic [AW-1:0]    accmodule;
    logic [N-1:0]     pending;
    logic [CNT_W-1:0] nb_interrupts;
    logic [CNT_W-1:0] nb_timeouts;
    logic [1:0]       dbg_state;

    timed_priority_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .done         (done),
        .grant        (grant),
        .accmodule    (accmodule),
        .pending      (pending),
        .nb_interrupts(nb_interrupts),
        .nb_timeouts  (nb_timeouts),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // holder = granted channel or -1 when idle.
    int         m_holder;
    int         m_last;
    int         m_hold;
    int         m_int;
    int         m_to;
    bit [N-1:0] m_pend;

    task automatic model_reset();
        m_holder = -1;
        m_last   = N - 1;
        m_hold   = 0;
        m_int    = 0;
        m_to     = 0;
        m_pend   = '0;
    endtask

    // Pick the next owner among the requests in e.
    task automatic model_arbitrate(input bit [N-1:0] e);
        int k;
        m_pend = e;
        if (e[0]) begin
            m_holder  = 0;
            m_pend[0] = 1'b0;
            return;
        end
        k = m_last;
        for (int s = 0; s < N - 1; s++) begin
            k = (k >= N - 1) ? 1 : k + 1;
            if (e[k]) begin
                m_holder  = k;
                m_last    = k;
                m_hold    = 1;
                m_pend[k] = 1'b0;
                return;
            end
        end
        m_holder = -1;
    endtask

    task automatic model_step(input bit [N-1:0] r, input bit [N-1:0] d);
        bit [N-1:0] e;
        bit [N-1:0] g;
        logic [EW-1:0] x;
        e = r;
        if (m_holder >= 0) e[m_holder] = 1'b0;
        e = e | m_pend;
        if (m_holder < 0) begin
            model_arbitrate(e);
        end else if (m_holder == 0) begin
            if (d[0]) model_arbitrate(e);
            else m_pend = e;
        end else if (d[m_holder]) begin
            model_arbitrate(e);
        end else if (e[0]) begin
            m_pend           = e;
            m_pend[m_holder] = 1'b1;
            m_pend[0]        = 1'b0;
            m_holder         = 0;
            if (m_int < 255) m_int++;
        end else if (m_hold == MAX_HOLD) begin
            if (m_to < 255) m_to++;
            model_arbitrate(e);
        end else begin
            m_hold++;
            m_pend = e;
        end
        g = '0;
        if (m_holder >= 0) g[m_holder] = 1'b1;
        x = {g, AW'(m_holder + 1), m_pend, CNT_W'(m_int), CNT_W'(m_to)};
        exp_q.push_back(x);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [EW-1:0] x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("grant",         int'(grant),         int'(x[EW-1 -: N]));
            check("accmodule",     int'(accmodule),     int'(x[EW-N-1 -: AW]));
            check("pending",       int'(pending),       int'(x[2*CNT_W+N-1 -: N]));
            check("nb_interrupts", int'(nb_interrupts), int'(x[2*CNT_W-1 -: CNT_W]));
            check("nb_timeouts",   int'(nb_timeouts),   int'(x[CNT_W-1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the following falling edge.
    task automatic drive(input bit [N-1:0] r, input bit [N-1:0] d);
        req  = r;
        done = d;
        model_step(r, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        req   = '0;
        done  = '0;
        reset = 1'b0;
        #1;
        check("rst_grant",     int'(grant),         0);
        check("rst_accmodule", int'(accmodule),     0);
        check("rst_pending",   int'(pending),       0);
        check("rst_nb_int",    int'(nb_interrupts), 0);
        check("rst_nb_to",     int'(nb_timeouts),   0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_acc[5];
        reset = 1'b1;
        req   = '0;
        done  = '0;
        model_reset();
        #2;
        do_reset();

        // Two-channel request, no done: both are cut off in turn.
        exp_acc = '{2, 2, 3, 3, 0};
        drive(4'b0110, 4'b0000);
        check("s2ch_acc0", int'(accmodule), exp_acc[0]);
        for (int i = 1; i < 5; i++) begin
            drive(4'b0000, 4'b0000);
            check("s2ch_acc", int'(accmodule), exp_acc[i]);
        end
        check("s2ch_timeouts", int'(nb_timeouts), 2);
        check("s2ch_grant_idle", int'(grant), 0);

        // Preemption of ch2, then ch2 re-granted on ch0's release edge.
        do_reset();
        drive(4'b0100, 4'b0000);
        check("pre_grant_ch2", int'(grant), 4'b0100);
        drive(4'b0001, 4'b0000);
        check("pre_grant_ch0", int'(grant), 4'b0001);
        check("pre_acc",       int'(accmodule), 1);
        check("pre_nb_int",    int'(nb_interrupts), 1);
        check("pre_pending2",  int'(pending[2]), 1);
        drive(4'b0000, 4'b0001);
        check("pre_regrant",   int'(grant), 4'b0100);
        check("pre_regrant_acc", int'(accmodule), 3);

        // Urgent grant has no timeout.
        drive(4'b0001, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            drive(4'b0000, 4'b0000);
            check("urg_hold", int'(grant), 4'b0001);
        end
        check("urg_no_timeout", int'(nb_timeouts), 0);
        drive(4'b0000, 4'b0001);
        drive(4'b0000, 4'b0000);
        drive(4'b0000, 4'b0000);

        // Done on ch1 with a new ch3 request: direct hand-over.
        do_reset();
        drive(4'b0010, 4'b0000);
        drive(4'b1000, 4'b0010);
        check("hand_grant", int'(grant), 4'b1000);
        check("hand_acc",   int'(accmodule), 4);
        check("hand_no_to", int'(nb_timeouts), 0);

        // Reset while ch3 is held.
        do_reset();

        // Saturation of the interrupt counter.
        drive(4'b0010, 4'b0000);
        for (int i = 0; i < 300; i++) begin
            drive(4'b0001, 4'b0000);
            drive(4'b0000, 4'b0001);
        end
        check("sat_nb_int", int'(nb_interrupts), 255);

        // Randomized traffic with occasional mid-run reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit [N-1:0] r;
            bit [N-1:0] d;
            r = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
            d = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
            if ($urandom_range(0, 299) == 0) do_reset();
            else drive(r, d);
        end

        drive(4'b0000, 4'b0000);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
